hmac_session_arbiter: RTL and testbench



---
 rtl/hmac_session_arbiter_if.sv | 42 ++++
 rtl/hmac_session_arbiter.sv | 166 ++++++++++++++++
 tb/tb_hmac_session_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hmac_session_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the HMAC session arbiter.
// The arbiter uses the slave view; clients and the engine use the master view.
interface hmac_session_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int N         = 256,
   parameter int r         = 16,
   parameter int KEY_WIDTH = 64,
   parameter int IW        = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*KEY_WIDTH-1:0] req_key;
   logic [NUM_REQ*r-1:0]         req_wdata;
   logic [NUM_REQ-1:0]           req_wvalid;
   logic [NUM_REQ-1:0]           req_wlast;
   logic [NUM_REQ-1:0]           req_grant;
   logic [NUM_REQ-1:0]           req_wready;
   logic [N-1:0]                 digest_out;
   logic                         digest_valid;
   logic [IW-1:0]                digest_owner;
   logic                         eng_rst;
   logic [r-1:0]                 eng_feed_data;
   logic                         eng_data_ready;
   logic                         eng_stop_feed;
   logic [KEY_WIDTH-1:0]         eng_key;
   logic                         eng_busy;
   logic [N-1:0]                 eng_digest;
   logic                         eng_end;

   modport master (
      output req_valid, req_key, req_wdata, req_wvalid, req_wlast,
      output eng_busy, eng_digest, eng_end,
      input  req_grant, req_wready, digest_out, digest_valid, digest_owner,
      input  eng_rst, eng_feed_data, eng_data_ready, eng_stop_feed, eng_key
   );

   modport slave (
      input  req_valid, req_key, req_wdata, req_wvalid, req_wlast,
      input  eng_busy, eng_digest, eng_end,
      output req_grant, req_wready, digest_out, digest_valid, digest_owner,
      output eng_rst, eng_feed_data, eng_data_ready, eng_stop_feed, eng_key
   );
endinterface

// File: rtl/hmac_session_arbiter.sv
// Round-robin arbiter handing one iterative HMAC engine to NUM_REQ requesters, one whole
// session at a time: key latch, paced word feed, stop_feed, digest capture, engine reset.
module hmac_session_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int N         = 256,
   parameter int r         = 16,
   parameter int KEY_WIDTH = 64,
   parameter int IW        = $clog2(NUM_REQ)
) (
   input logic                   clk,
   input logic                   rst,
   hmac_session_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      ST_ARB      = 3'd0,
      ST_LOAD     = 3'd1,
      ST_ISSUE    = 3'd2,
      ST_ACK      = 3'd3,
      ST_DRAIN    = 3'd4,
      ST_STOP     = 3'd5,
      ST_WAIT_END = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   state_t               state_r;
   logic [NUM_REQ-1:0]   grant_r;
   logic [IW-1:0]        owner_r;
   logic [IW-1:0]        last_owner_r;
   logic [IW-1:0]        digest_owner_r;
   logic [KEY_WIDTH-1:0] key_r;
   logic [r-1:0]         feed_r;
   logic                 last_r;
   logic                 data_ready_r;
   logic                 stop_feed_r;
   logic [N-1:0]         digest_r;
   logic                 digest_valid_r;

   logic                 hit_s;
   logic [IW-1:0]        pick_s;
   logic [IW-1:0]        cand_s;
   logic [r-1:0]         wdata_s [NUM_REQ];
   logic [KEY_WIDTH-1:0] key_s   [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign wdata_s[gi] = bus.req_wdata[gi*r +: r];
      assign key_s[gi]   = bus.req_key[gi*KEY_WIDTH +: KEY_WIDTH];
   end

   // Round-robin pick: first valid requester after the previous owner, wrapping at NUM_REQ
   always_comb begin
      hit_s  = 1'b0;
      pick_s = {IW{1'b0}};
      cand_s = {IW{1'b0}};
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand_s = IW'((int'(last_owner_r) + k) % NUM_REQ);
         if (!hit_s && bus.req_valid[cand_s]) begin
            hit_s  = 1'b1;
            pick_s = cand_s;
         end else begin
            hit_s  = hit_s;
         end
      end
   end

   // Session sequencer; the hold register only moves in LOAD, so the engine's late sample is safe
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_ARB;
         grant_r        <= {NUM_REQ{1'b0}};
         owner_r        <= {IW{1'b0}};
         last_owner_r   <= IW'(NUM_REQ - 1);
         digest_owner_r <= {IW{1'b0}};
         key_r          <= {KEY_WIDTH{1'b0}};
         feed_r         <= {r{1'b0}};
         last_r         <= 1'b0;
         data_ready_r   <= 1'b0;
         stop_feed_r    <= 1'b0;
         digest_r       <= {N{1'b0}};
         digest_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_ARB: begin
               if (hit_s) begin
                  grant_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                  owner_r <= pick_s;
                  key_r   <= key_s[pick_s];
                  state_r <= ST_LOAD;
               end else begin
                  state_r <= ST_ARB;
               end
            end
            ST_LOAD: begin
               if (bus.req_wvalid[owner_r]) begin
                  feed_r  <= wdata_s[owner_r];
                  last_r  <= bus.req_wlast[owner_r];
                  state_r <= ST_ISSUE;
               end else begin
                  state_r <= ST_LOAD;
               end
            end
            ST_ISSUE: begin
               if (!bus.eng_busy) begin
                  data_ready_r <= 1'b1;
                  state_r      <= ST_ACK;
               end else begin
                  state_r      <= ST_ISSUE;
               end
            end
            ST_ACK: begin
               data_ready_r <= 1'b0;
               if (bus.eng_busy) begin
                  state_r <= ST_DRAIN;
               end else begin
                  state_r <= ST_ACK;
               end
            end
            ST_DRAIN: begin
               if (!bus.eng_busy && last_r) begin
                  stop_feed_r <= 1'b1;
                  state_r     <= ST_STOP;
               end else if (!bus.eng_busy) begin
                  state_r     <= ST_LOAD;
               end else begin
                  state_r     <= ST_DRAIN;
               end
            end
            ST_STOP: begin
               stop_feed_r <= 1'b0;
               state_r     <= ST_WAIT_END;
            end
            ST_WAIT_END: begin
               if (bus.eng_end) begin
                  digest_r       <= bus.eng_digest;
                  digest_owner_r <= owner_r;
                  digest_valid_r <= 1'b1;
                  state_r        <= ST_DONE;
               end else begin
                  state_r        <= ST_WAIT_END;
               end
            end
            ST_DONE: begin
               digest_valid_r <= 1'b0;
               grant_r        <= {NUM_REQ{1'b0}};
               last_owner_r   <= owner_r;
               state_r        <= ST_ARB;
            end
            default: begin
               state_r <= ST_ARB;
            end
         endcase
      end
   end

   assign bus.req_grant      = grant_r;
   assign bus.req_wready     = (state_r == ST_LOAD) ? grant_r : {NUM_REQ{1'b0}};
   assign bus.digest_out     = digest_r;
   assign bus.digest_valid   = digest_valid_r;
   assign bus.digest_owner   = digest_owner_r;
   assign bus.eng_rst        = rst | (state_r == ST_DONE);
   assign bus.eng_feed_data  = feed_r;
   assign bus.eng_data_ready = data_ready_r;
   assign bus.eng_stop_feed  = stop_feed_r;
   assign bus.eng_key        = key_r;

endmodule

// File: tb/tb_hmac_session_arbiter.sv
// Scoreboard bench for hmac_session_arbiter: per-requester client drivers, a behavioural
// iterative engine with a late data sample, and a monitor checking every digest_valid.
module tb_hmac_session_arbiter;
   localparam int NR = 4;
   localparam int N  = 256;
   localparam int R  = 16;
   localparam int KW = 64;
   localparam int IW = 2;

   typedef struct packed {
      logic [IW-1:0] own;
      logic [N-1:0]  dig;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   hmac_session_arbiter_if #(.NUM_REQ(NR), .N(N), .r(R), .KEY_WIDTH(KW)) bus ();

   hmac_session_arbiter #(.NUM_REQ(NR), .N(N), .r(R), .KEY_WIDTH(KW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        exp_q[$];
   logic [KW-1:0] keys [NR];
   logic [R-1:0]  words [NR][8];
   int          nw [NR];
   int          gmax [NR];
   int          req_cnt [NR];
   logic [NR-1:0] idle_v;
   logic [NR-1:0] to_v;
   logic        tog_wvalid, tog_wlast;

   function automatic logic [N-1:0] init_state(input logic [KW-1:0] k);
      return {k, ~k, k ^ 64'h9E3779B97F4A7C15, k[31:0], k[63:32]};
   endfunction

   function automatic logic [N-1:0] absorb(input logic [N-1:0] a, input logic [R-1:0] w);
      logic [N-1:0] t;
      t = {a[N-R-1:0], a[N-1:N-R] ^ w};
      return t ^ (t >> 3);
   endfunction

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h", nm, act, req);
      end
   endtask

   // Client drivers: request, drop req_valid once granted, then stream words with random gaps
   for (genvar g = 0; g < NR; g++) begin : g_cli
      logic         valid, wvalid, wlast, to_l;
      logic [R-1:0] wdata;
      int           served;
      assign bus.req_valid[g]          = valid;
      assign bus.req_wvalid[g]         = wvalid | ((g == NR-1) ? tog_wvalid : 1'b0);
      assign bus.req_wlast[g]          = wlast  | ((g == NR-1) ? tog_wlast  : 1'b0);
      assign bus.req_wdata[g*R +: R]   = wdata;
      assign bus.req_key[g*KW +: KW]   = keys[g];
      assign idle_v[g]                 = (served == req_cnt[g]);
      assign to_v[g]                   = to_l;
      initial begin
         valid = 1'b0; wvalid = 1'b0; wlast = 1'b0; wdata = '0; served = 0; to_l = 1'b0;
         forever begin
            wait (req_cnt[g] != served);
            @(negedge clk);
            valid = 1'b1;
            for (int t = 0; t < 4000 && bus.req_grant[g] !== 1'b1; t++) @(negedge clk);
            if (bus.req_grant[g] !== 1'b1) to_l = 1'b1;
            valid = 1'b0;
            for (int j = 0; j < nw[g]; j++) begin
               repeat ($urandom_range(gmax[g], 0)) @(negedge clk);
               wvalid = 1'b1;
               wdata  = words[g][j];
               wlast  = (j == nw[g] - 1);
               for (int t = 0; t < 500 && bus.req_wready[g] !== 1'b1; t++) @(negedge clk);
               if (bus.req_wready[g] !== 1'b1) to_l = 1'b1;
               @(negedge clk);
               wvalid = 1'b0;
               wlast  = 1'b0;
            end
            served = served + 1;
         end
      end
   end

   // Behavioural engine: busy after data_ready, samples the word only at the end of busy
   logic         eb = 1'b0, eend = 1'b0, started = 1'b0, stopping = 1'b0;
   logic [N-1:0] acc = '0, edig = '0;
   logic [R-1:0] held = '0;
   int           ecnt = 0, scnt = 0, hold_viol = 0;
   assign bus.eng_busy   = eb;
   assign bus.eng_end    = eend;
   assign bus.eng_digest = edig;

   always @(posedge clk) begin
      if (bus.eng_rst) begin
         eb <= 1'b0; eend <= 1'b0; started <= 1'b0; stopping <= 1'b0; ecnt <= 0; scnt <= 0;
      end else begin
         if (bus.eng_data_ready && !eb) begin
            eb   <= 1'b1;
            ecnt <= 2 + int'($urandom_range(3, 0));
            held <= bus.eng_feed_data;
            if (!started) acc <= init_state(bus.eng_key);
            started <= 1'b1;
         end else if (eb) begin
            if (bus.eng_feed_data !== held) hold_viol <= hold_viol + 1;
            if (ecnt == 0) begin
               acc <= absorb(acc, bus.eng_feed_data);
               eb  <= 1'b0;
            end else begin
               ecnt <= ecnt - 1;
            end
         end
         if (bus.eng_stop_feed) begin
            stopping <= 1'b1;
            scnt     <= 3;
         end else if (stopping && !eend) begin
            if (scnt == 0) begin
               eend <= 1'b1;
               edig <= acc;
            end else begin
               scnt <= scnt - 1;
            end
         end
      end
   end

   // Event counters and protocol watchers
   int   n_dr = 0, n_stop = 0, n_rise = 0, n_dv = 0, drb_viol = 0, wr_viol = 0;
   logic erst_q = 1'b1;
   always @(negedge clk) begin
      erst_q <= bus.eng_rst;
      if (bus.eng_data_ready === 1'b1) n_dr <= n_dr + 1;
      if (bus.eng_stop_feed === 1'b1) n_stop <= n_stop + 1;
      if (bus.digest_valid === 1'b1) n_dv <= n_dv + 1;
      if (bus.eng_rst === 1'b1 && erst_q !== 1'b1) n_rise <= n_rise + 1;
      if (bus.eng_data_ready === 1'b1 && eb) drb_viol <= drb_viol + 1;
      if ((bus.req_wready & ~bus.req_grant) != '0) wr_viol <= wr_viol + 1;
   end

   // Monitor: every digest_valid pops one expected {owner, digest}
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.digest_valid === 1'b1) begin
            chk("digest_expected", N'(exp_q.size() != 0), N'(1));
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("digest_owner", N'(bus.digest_owner), N'(e.own));
               chk("digest_out", bus.digest_out, e.dig);
               chk("eng_rst_at_done", N'(bus.eng_rst), N'(1));
            end
         end
      end
   end

   task automatic setup(input int i, input logic [KW-1:0] k, input int n,
                        input logic [R-1:0] base, input logic [R-1:0] step,
                        input int gm, input bit push);
      logic [N-1:0] a;
      exp_t         e;
      keys[i] = k;
      nw[i]   = n;
      gmax[i] = gm;
      a = init_state(k);
      for (int j = 0; j < n; j++) begin
         words[i][j] = base + step * R'(j);
         a = absorb(a, words[i][j]);
      end
      if (push) begin
         e.own = IW'(i);
         e.dig = a;
         exp_q.push_back(e);
      end
      req_cnt[i] = req_cnt[i] + 1;
   endtask

   task automatic wait_drain(input string nm);
      for (int t = 0; t < 6000 && !(exp_q.size() == 0 && idle_v == '1); t++) @(negedge clk);
      chk(nm, N'(exp_q.size() == 0 && idle_v == '1), N'(1));
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_grant"},      N'(bus.req_grant),      N'(0));
      chk({nm, "_wready"},     N'(bus.req_wready),     N'(0));
      chk({nm, "_dvalid"},     N'(bus.digest_valid),   N'(0));
      chk({nm, "_dout"},       bus.digest_out,         N'(0));
      chk({nm, "_downer"},     N'(bus.digest_owner),   N'(0));
      chk({nm, "_dready"},     N'(bus.eng_data_ready), N'(0));
      chk({nm, "_stop"},       N'(bus.eng_stop_feed),  N'(0));
      chk({nm, "_feed"},       N'(bus.eng_feed_data),  N'(0));
      chk({nm, "_key"},        N'(bus.eng_key),        N'(0));
      chk({nm, "_eng_rst"},    N'(bus.eng_rst),        N'(1));
   endtask

   initial begin
      int d0, s0, r0, v0;
      logic iso;
      rst = 1'b1;
      tog_wvalid = 1'b0;
      tog_wlast  = 1'b0;
      for (int i = 0; i < NR; i++) begin
         keys[i] = '0; nw[i] = 0; gmax[i] = 0; req_cnt[i] = 0;
      end
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single one-word session from requester 0
      d0 = n_dr; s0 = n_stop; r0 = n_rise;
      setup(0, 64'h0123456789ABCDEF, 1, 16'hABCD, 16'h0000, 0, 1'b1);
      wait_drain("single_drain");
      chk("single_dready_pulses", N'(n_dr - d0),   N'(1));
      chk("single_stop_pulses",   N'(n_stop - s0), N'(1));
      chk("single_eng_rst_pulses", N'(n_rise - r0), N'(1));

      // All four requesting at reset release, then only 1 and 3
      rst = 1'b1;
      for (int i = 0; i < NR; i++)
         setup(i, 64'hA5A5_0000_0000_0000 | KW'(i), 3, R'(16'h1000 * i + 1), 16'h0111, 0, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      wait_drain("rr4_drain");
      setup(1, 64'h1111_2222_3333_4444, 3, 16'h0F0F, 16'h2222, 0, 1'b1);
      setup(3, 64'h5555_6666_7777_8888, 3, 16'hF0F0, 16'h0303, 0, 1'b1);
      wait_drain("rr13_drain");

      // Word hold: continuous words 1..4 from requester 2
      setup(2, 64'hDEAD_BEEF_CAFE_F00D, 4, 16'h0001, 16'h0001, 0, 1'b1);
      wait_drain("hold_drain");

      // Same message without and with stalls must give the same digest
      setup(0, 64'h0BAD_C0DE_1234_5678, 5, 16'hBEEF, 16'h1357, 0, 1'b1);
      wait_drain("nogap_drain");
      setup(0, 64'h0BAD_C0DE_1234_5678, 5, 16'hBEEF, 16'h1357, 20, 1'b1);
      wait_drain("stall_drain");

      // Requester 3 toggles its word lines while requester 0 owns the engine
      setup(0, 64'h1357_9BDF_2468_ACE0, 4, 16'h4321, 16'h0101, 6, 1'b1);
      iso = 1'b0;
      for (int t = 0; t < 80; t++) begin
         tog_wvalid = 1'($urandom_range(1, 0));
         tog_wlast  = 1'($urandom_range(1, 0));
         @(negedge clk);
         iso = iso | bus.req_wready[NR-1];
      end
      tog_wvalid = 1'b0;
      tog_wlast  = 1'b0;
      chk("iso_wready3", N'(iso), N'(0));
      wait_drain("iso_drain");

      // Reset during WAIT_END aborts the session without a digest
      setup(2, 64'hFEED_FACE_0000_1111, 3, 16'h7777, 16'h0011, 0, 1'b0);
      for (int t = 0; t < 3000 && bus.eng_stop_feed !== 1'b1; t++) @(negedge clk);
      chk("abort_stop_seen", N'(bus.eng_stop_feed), N'(1));
      @(negedge clk);
      rst = 1'b1;
      v0 = n_dv;
      @(negedge clk);
      check_reset("abort");
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("abort_no_digest", N'(n_dv - v0), N'(0));
      wait_drain("abort_drain");
      setup(1, 64'h0F1E_2D3C_4B5A_6978, 2, 16'h9999, 16'h0123, 0, 1'b1);
      wait_drain("after_abort_drain");

      chk("dready_while_busy", N'(drb_viol),  N'(0));
      chk("feed_hold",         N'(hold_viol), N'(0));
      chk("wready_non_owner",  N'(wr_viol),   N'(0));
      chk("client_timeout",    N'(to_v),      N'(0));
      chk("leftover_expected", N'(exp_q.size()), N'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
